// File: rtl/maj_net_eval.sv
// maj_net_eval: programmable chain of 3-input majority nodes with per-operand
// inversion, evaluated one node per clock. Single-vector mode returns the
// function value; sweep mode walks all 2^N_IN vectors and counts the ON-set.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data node config write {inv2,sel2,inv1,sel1,inv0,sel0}
//   in_valid/in_ready        request handshake (in_vec, in_sweep)
//   out_valid/out_ready      result handshake (out_bit, out_count)
//   busy                     high whenever the FSM is not IDLE
module maj_net_eval #(
   parameter  int unsigned N_IN    = 7,
   parameter  int unsigned N_NODES = 6,
   localparam int unsigned IDX_W   = $clog2(1 + N_IN + N_NODES),
   localparam int unsigned ADDR_W  = $clog2(N_NODES),
   localparam int unsigned ENT_W   = IDX_W + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [ADDR_W-1:0]    cfg_addr,
   input  logic [3*ENT_W-1:0]   cfg_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_IN-1:0]      in_vec,
   input  logic                 in_sweep,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_bit,
   output logic [N_IN:0]        out_count,
   output logic                 busy
);

   localparam int unsigned SIG_W = 1 << IDX_W;

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   state_t               state_q, state_d;
   logic [3*ENT_W-1:0]   cfg_q [N_NODES];
   logic [N_NODES-1:0]   node_q;
   logic [ADDR_W-1:0]    idx_q;
   logic [N_IN-1:0]      vec_q;
   logic                 sweep_q;
   logic [N_IN:0]        count_q;

   logic                 accept, last_node, last_vec;
   logic [SIG_W-1:0]     sig;
   logic [3*ENT_W-1:0]   ent;
   logic [2:0]           op;
   logic                 node_c;
   logic                 in_ready_d, out_valid_d, busy_d;

   assign accept    = in_valid && in_ready && (state_q == IDLE);
   assign last_node = (idx_q == ADDR_W'(N_NODES - 1));
   assign last_vec  = !sweep_q || (&vec_q);
   assign out_count = count_q;

   // Selector space laid out as one flat vector: const0, inputs, nodes, then
   // zero padding for out-of-range codes. Nodes at or above the current index
   // are masked so stale values from the previous vector never leak in.
   always_comb begin
      sig = '0;
      sig[N_IN:1] = vec_q;
      for (int j = 0; j < N_NODES; j++) begin
         if (ADDR_W'(j) < idx_q) sig[1 + N_IN + j] = node_q[j];
      end
      ent = cfg_q[idx_q];
      for (int o = 0; o < 3; o++) begin
         op[o] = sig[ent[o*ENT_W +: IDX_W]] ^ ent[o*ENT_W + IDX_W];
      end
      node_c = (op[0] & op[1]) | (op[0] & op[2]) | (op[1] & op[2]);
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      case (state_q)
         IDLE:    if (accept) state_d = EVAL;
         EVAL:    if (last_node && last_vec) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // State, handshake flags, configuration and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out_bit   <= 1'b0;
         count_q   <= '0;
         idx_q     <= '0;
         vec_q     <= '0;
         sweep_q   <= 1'b0;
         node_q    <= '0;
         for (int k = 0; k < N_NODES; k++) cfg_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         busy      <= busy_d;

         if (cfg_we && (state_q == IDLE) && (32'(cfg_addr) < N_NODES))
            cfg_q[cfg_addr] <= cfg_data;

         case (state_q)
            IDLE: begin
               if (accept) begin
                  vec_q   <= in_sweep ? '0 : in_vec;
                  sweep_q <= in_sweep;
                  count_q <= '0;
                  idx_q   <= '0;
               end
            end
            EVAL: begin
               node_q[idx_q] <= node_c;
               if (last_node) begin
                  out_bit <= node_c;
                  if (sweep_q) begin
                     count_q <= count_q + (N_IN + 1)'(node_c);
                     if (!(&vec_q)) begin
                        vec_q <= vec_q + N_IN'(1);
                        idx_q <= '0;
                     end
                  end
               end else begin
                  idx_q <= idx_q + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_maj_net_eval.sv
// tb_maj_net_eval: scoreboard bench for maj_net_eval. Stimulus pushes the
// reference-model result per request; a negedge monitor pops and compares
// whenever out_valid appears, and drives out_ready (with optional stall).
module tb_maj_net_eval;

   localparam int N_IN    = 7;
   localparam int N_NODES = 6;
   localparam int N_VEC   = 1 << N_IN;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [14:0] cfg_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_vec = '0;
   logic        in_sweep = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_bit;
   logic [7:0]  out_count;
   logic        busy;

   maj_net_eval dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_sweep(in_sweep),
      .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
      .out_count(out_count), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct { int b; int cnt; int lat; int acc; } exp_t;
   exp_t sbq[$];
   exp_t cur;

   int msel [N_NODES][3];
   int minv [N_NODES][3];
   int tests = 0;
   int fails = 0;
   int stall = 0;
   bit seen  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: evaluate nodes in order from selector arithmetic
   function automatic int model_f(input int v);
      int n [N_NODES];
      int ones, val, s;
      for (int k = 0; k < N_NODES; k++) begin
         ones = 0;
         for (int o = 0; o < 3; o++) begin
            s = msel[k][o];
            val = 0;
            if (s >= 1 && s <= N_IN) val = (v >> (s - 1)) & 1;
            else if (s > N_IN && s <= N_IN + N_NODES && (s - N_IN - 1) < k) val = n[s - N_IN - 1];
            ones += val ^ minv[k][o];
         end
         n[k] = (ones >= 2) ? 1 : 0;
      end
      return n[N_NODES-1];
   endfunction

   task automatic model_clear();
      for (int k = 0; k < N_NODES; k++)
         for (int o = 0; o < 3; o++) begin
            msel[k][o] = 0;
            minv[k][o] = 0;
         end
   endtask

   task automatic cfg_raw(input int k, input logic [14:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 3'(k); cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic set_node(input int k, input int s0, input int i0, input int s1,
                           input int i1, input int s2, input int i2);
      logic [14:0] d;
      d = {1'(i2), 4'(s2), 1'(i1), 4'(s1), 1'(i0), 4'(s0)};
      cfg_raw(k, d);
      msel[k][0] = s0; minv[k][0] = i0;
      msel[k][1] = s1; minv[k][1] = i1;
      msel[k][2] = s2; minv[k][2] = i2;
   endtask

   task automatic run(input bit sw, input int v);
      exp_t e;
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 3000) begin @(negedge clk); t++; end
      if (!in_ready) begin chk("ready_timeout", 0, 1); return; end
      in_valid = 1'b1; in_sweep = sw; in_vec = 7'(v);
      if (sw) begin
         e.cnt = 0;
         for (int x = 0; x < N_VEC; x++) e.cnt += model_f(x);
         e.b   = model_f(N_VEC - 1);
         e.lat = N_NODES * N_VEC;
      end else begin
         e.b   = model_f(v);
         e.cnt = 0;
         e.lat = N_NODES;
      end
      @(negedge clk);
      in_valid = 1'b0;
      e.acc = cyc;
      chk("accept_busy", int'(busy), 1);
      sbq.push_back(e);
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((sbq.size() != 0 || !in_ready || out_valid) && t < 2000) begin
         @(negedge clk); t++;
      end
      if (t >= 2000) chk("idle_timeout", 0, 1);
   endtask

   // Monitor: compare first out_valid cycle, check stability while stalled
   always @(negedge clk) begin
      if (rst) begin
         out_ready = 1'b0;
         seen = 1'b0;
      end else if (out_valid) begin
         if (!seen) begin
            seen = 1'b1;
            if (sbq.size() == 0) begin
               chk("unexpected_out", 1, 0);
               cur.b = int'(out_bit); cur.cnt = int'(out_count);
            end else begin
               cur = sbq.pop_front();
               chk("out_bit", int'(out_bit), cur.b);
               chk("out_count", int'(out_count), cur.cnt);
               chk("latency", cyc - cur.acc, cur.lat);
            end
         end else begin
            chk("stall_bit", int'(out_bit), cur.b);
            chk("stall_count", int'(out_count), cur.cnt);
            chk("stall_in_ready", int'(in_ready), 0);
         end
         if (stall > 0) begin stall--; out_ready = 1'b0; end
         else out_ready = 1'b1;
      end else begin
         if (seen) begin
            chk("valid_held_until_ready", int'(out_ready), 1);
            chk("ready_after_hs", int'(in_ready), 1);
         end
         seen = 1'b0;
         out_ready = 1'b0;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_bit", int'(out_bit), 0);
      chk("rst_out_count", int'(out_count), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_reset", int'(in_ready), 1);

      // unconfigured network sweeps to all zeros
      model_clear();
      run(1'b1, 0); wait_idle();

      // forward reference from n0 to n3 reads 0 even when n3 holds 1
      set_node(3, 0, 1, 0, 1, 0, 1);
      set_node(0, 11, 0, 0, 1, 0, 0);
      set_node(5, 8, 0, 0, 1, 0, 0);
      run(1'b0, int'($urandom_range(0, 127))); wait_idle();
      run(1'b0, int'($urandom_range(0, 127))); wait_idle();

      // reference network
      set_node(0, 4, 0, 6, 0, 7, 0);
      set_node(1, 1, 0, 2, 0, 3, 0);
      set_node(2, 5, 0, 6, 0, 8, 0);
      set_node(3, 2, 0, 3, 0, 5, 0);
      set_node(4, 1, 0, 10, 0, 11, 0);
      set_node(5, 4, 0, 9, 0, 12, 0);
      run(1'b0, 'h7F); wait_idle();
      run(1'b0, 'h00); wait_idle();
      run(1'b0, 'h0F); wait_idle();

      // long output stall
      stall = 20;
      run(1'b0, 'h7F); wait_idle();

      // config write while busy must be dropped
      run(1'b0, 'h0F);
      cfg_raw(5, 15'h4210);
      wait_idle();
      run(1'b0, 'h00); wait_idle();

      // sweep ON-set sizes
      set_node(5, 1, 0, 2, 0, 3, 0);
      run(1'b1, 0); wait_idle();
      set_node(5, 1, 0, 2, 0, 0, 0);
      run(1'b1, 0); wait_idle();
      set_node(5, 0, 1, 1, 0, 2, 0);
      run(1'b1, 0); wait_idle();

      // random networks, including forward and out-of-range selectors
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < N_NODES; k++)
            set_node(k, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
         for (int t = 0; t < 4; t++) begin
            run(1'b0, int'($urandom_range(0, 127))); wait_idle();
         end
         run(1'b1, 0); wait_idle();
      end

      // reset mid-sweep aborts and clears config
      set_node(5, 0, 1, 0, 1, 0, 1);
      run(1'b1, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_in_ready", int'(in_ready), 0);
      sbq.delete();
      model_clear();
      rst = 1'b0;
      run(1'b0, int'($urandom_range(0, 127))); wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/maj_net_eval.md
# maj_net_eval

Programmable majority-network evaluator for the 7-input function-classification flow. It holds a configurable chain of N_NODES three-input majority nodes with per-operand inversion, and evaluates the chain one node per clock. It has two modes: single-vector evaluation, and an exhaustive sweep that counts the ON-set size over all 2^N_IN input vectors. It replaces hard-wired per-function majority netlists: one instance is reconfigured per candidate function.

## Interface
Parameters:
- N_IN, 7: number of primary inputs x0..x(N_IN-1)
- N_NODES, 6: number of majority nodes; the last node is the output
- IDX_W, derived = clog2(1+N_IN+N_NODES): operand selector width (not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  configuration write strobe
- cfg_addr  in  clog2(N_NODES)  node index to write
- cfg_data  in  3*(IDX_W+1)  packed {inv2,sel2,inv1,sel1,inv0,sel0}
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when high with in_valid
- in_vec  in  N_IN  input vector for single evaluation
- in_sweep  in  1  1 = sweep all 2^N_IN vectors; in_vec ignored
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_bit  out  1  function value (single mode) or f(all-ones) (sweep mode)
- out_count  out  N_IN+1  ON-set size (sweep mode); 0 in single mode
- busy  out  1  high in any state other than IDLE

## Operation
- Selector encoding:
  - 0 = constant 0
  - 1..N_IN = x(sel-1)
  - N_IN+1..N_IN+N_NODES = node (sel-N_IN-1)
- The operand value is the selected signal XOR its inv bit; inv on selector 0 gives constant 1.
- Node k = MAJ(op0,op1,op2).
- These selectors read 0 before inversion:
  - a selector naming node j with j ≥ k (forward or self reference);
  - an out-of-range selector.
- Config writes take effect only in IDLE. A write while busy is ignored.
- Reset clears all config to 0, so every node evaluates to 0.
- States: IDLE, EVAL, DONE.
  - IDLE: in_ready=1. On in_valid, latch in_vec (sweep: vector counter=0, count=0), node index=0, go to EVAL.
  - EVAL: compute node[idx] into the node-value register each cycle and increment idx. After node N_NODES-1:
    - Single mode: go to DONE.
    - Sweep mode: add the result to count. If the vector is all-ones, go to DONE; otherwise increment the vector, reset idx=0 and stay in EVAL.
  - DONE: out_valid=1 with out_bit/out_count held stable. When out_ready=1, go to IDLE.
- out_count is exact up to 2^N_IN; its width N_IN+1 means there is no overflow.
- Node-value registers are not cleared between vectors. The forward-reference rule makes stale values unobservable.

## Timing
- Reset values:
  - in_ready=0 during reset, 1 in the first cycle after reset.
  - out_valid=0, out_bit=0, out_count=0, busy=0, state=IDLE, config all 0.
- Accept edge = T0. Node k is computed on edge T(k+1).
- Single mode: out_valid goes high after edge T(N_NODES), i.e. latency of N_NODES cycles from acceptance.
- Sweep mode: out_valid goes high N_NODES·2^N_IN cycles after acceptance.
- The in_ready low period is:
  - from the accept edge until the cycle after the out_valid&out_ready handshake;
  - with no back-to-back acceptance in the handshake cycle.
- Outputs stay stable while out_valid=1 and out_ready=0, with no limit on stall length.
- in_valid is ignored while not in IDLE.
- rst asserted mid-EVAL or mid-DONE aborts the operation and clears config on the next edge.

## Test plan
- Config n0=MAJ(x3,x5,x6), n1=MAJ(x0,x1,x2), n2=MAJ(x4,x5,n0), n3=MAJ(x1,x2,x4), n4=MAJ(x0,n2,n3), n5=MAJ(x3,n1,n4). Required responses:
  - in_vec=7'h7F -> out_bit=1
  - in_vec=7'h00 -> out_bit=0
  - in_vec=7'h0F -> out_bit=1
  - out_valid exactly 6 cycles after acceptance in every case.
- Config n5=MAJ(x0,x1,x2), sweep -> out_count=64, out_bit=1, latency 768 cycles.
- Config n5=MAJ(x0,x1,const0), sweep -> out_count=32. Config n5=MAJ(~const0,x0,x1), sweep -> out_count=96.
- After reset with no config writes, sweep -> out_count=0, out_bit=0. Config n0 selecting node 3 (forward reference) -> n0 reads 0.
- Hold out_ready=0 for 20 cycles -> out_valid and out_bit stable, in_ready=0. A cfg_we issued during EVAL has no effect on the current or next result.
- Assert rst 3 cycles into a sweep -> busy=0 and out_valid=0 after one edge. A new single evaluation then gives out_bit=0.
